// File: rtl/pc_sequencer_if.sv
// Bus between the branch-decision unit and the PC register stage.
// The master drives the next-PC request and the slave returns the PC and stack status.
interface pc_sequencer_if #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

    // No handshake: when en is 1 at a rising edge the sequencer takes one step.
    // en, sel, ret, target and offset are only sampled at that edge.
    logic               en;
    logic [1:0]         sel;
    logic               ret;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    offset;
    logic [PC_W-1:0]    pc;
    logic [DEPTH_W-1:0] depth;
    logic               stack_full;
    logic               stack_empty;
    logic               stack_err;

    modport master (
        output en, sel, ret, target, offset,
        input  pc, depth, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  en, sel, ret, target, offset,
        output pc, depth, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter register with a small circular return-address stack.
// It performs one update per enabled cycle. The outputs come only from registers.
module pc_sequencer #(
    parameter int              PC_W        = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_sequencer_if.slave     seq
);
    localparam int                 SP_W      = $clog2(STACK_DEPTH);
    localparam int                 DEPTH_W   = SP_W + 1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic [PC_W-1:0]    stack_q [STACK_DEPTH];

    logic [PC_W-1:0]    pc_inc;
    logic [SP_W-1:0]    sp_dec;
    logic               push_en;

    assign pc_inc = pc_q + PC_W'(1);
    assign sp_dec = sp_q - SP_W'(1);

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (seq.en) begin
            if (seq.ret) begin
                if (depth_q != '0) begin
                    pc_d    = stack_q[sp_dec];
                    sp_d    = sp_dec;
                    depth_d = depth_q - DEPTH_W'(1);
                end else begin
                    // Underflow: fall through to the next instruction.
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end
            end else begin
                case (seq.sel)
                    2'b00: pc_d = pc_inc;
                    2'b01: pc_d = pc_q + seq.offset;
                    2'b10: pc_d = seq.target;
                    2'b11: begin
                        // When the stack is full, sp already points at the oldest entry.
                        push_en = 1'b1;
                        pc_d    = seq.target;
                        sp_d    = sp_q + SP_W'(1);
                        if (depth_q == DEPTH_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            depth_d = depth_q + DEPTH_W'(1);
                        end
                    end
                    default: pc_d = pc_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            sp_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // The stack contents are not reset. Only the pointer and depth define which entries are valid.
    always_ff @(posedge clk) begin
        if (rst_n && push_en) begin
            stack_q[sp_q] <= pc_inc;
        end
    end

    assign seq.pc          = pc_q;
    assign seq.depth       = depth_q;
    assign seq.stack_full  = (depth_q == DEPTH_MAX);
    assign seq.stack_empty = (depth_q == '0);
    assign seq.stack_err   = err_q;
endmodule
